// File: rtl/seg_pkg.sv
// seg_pkg: shared digit widths, owner states and anode table for the display arbiter.
package seg_pkg;
    localparam int DIGIT_W = 5;
    localparam int NUM_DIGITS = 4;
    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} owner_t;
    localparam logic [NUM_DIGITS-1:0][3:0] ANODE_ON = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    localparam logic [3:0] ANODE_OFF = 4'b1111;
endpackage

// File: rtl/scan_timer.sv
// scan_timer: per-slot tick counter and 4-slot scan counter; flags the blank window and frame boundary.
module scan_timer #(
    parameter int PERIOD = 100000,
    parameter int BLANK_CYC = 2000
) (
    input logic clk,
    input logic reset,
    output logic [1:0] slot,
    output logic blank,
    output logic frame_boundary
);
    localparam int TW = $clog2(PERIOD);
    logic [TW-1:0] tick;
    logic wrap;
    assign wrap = tick == TW'(PERIOD - 1);
    assign blank = tick < TW'(BLANK_CYC);
    assign frame_boundary = wrap && slot == 2'd3;
    always_ff @(posedge clk) begin
        if (reset) begin
            tick <= '0;
            slot <= '0;
        end else begin
            tick <= wrap ? '0 : tick + 1'b1;
            slot <= wrap ? slot + 1'b1 : slot;
        end
    end
endmodule

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: frame-aligned A/B ownership of a 4-digit seven-segment display with snapshot and scan drive.
// Optional BLINK_EN adds blink_mask and a frame counter whose MSB blanks masked slots.
module seg_display_arbiter
    import seg_pkg::*;
#(
    parameter int PERIOD = 100000,
    parameter int BLANK_CYC = 2000,
    parameter int HOLD_FRAMES = 8
) (
    input logic clk,
    input logic reset,
    input logic req_a,
    input logic [NUM_DIGITS*DIGIT_W-1:0] dig_a,
    input logic req_b,
    input logic [NUM_DIGITS*DIGIT_W-1:0] dig_b,
`ifdef BLINK_EN
    input logic [NUM_DIGITS-1:0] blink_mask,
`endif
    output logic gnt_a,
    output logic gnt_b,
    output logic frame_start,
    output logic [DIGIT_W-1:0] led_output,
    output logic [3:0] an
);
    logic [1:0] slot;
    logic blank;
    logic frame_boundary;
    logic eligible;
    logic dark;
    logic [7:0] hold;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] snap;
    owner_t state, state_next;

    scan_timer #(.PERIOD(PERIOD), .BLANK_CYC(BLANK_CYC)) u_scan (
        .clk(clk),
        .reset(reset),
        .slot(slot),
        .blank(blank),
        .frame_boundary(frame_boundary)
    );

    assign eligible = hold >= 8'(HOLD_FRAMES);
    assign gnt_a = state == OWN_A;
    assign gnt_b = state == OWN_B;

    always_comb begin
        state_next = state;
        if (frame_boundary)
            case (state)
                IDLE: state_next = req_a ? OWN_A : req_b ? OWN_B : IDLE;
                OWN_A: state_next = (!eligible || req_a) ? OWN_A : req_b ? OWN_B : IDLE;
                OWN_B: state_next = !eligible ? OWN_B : req_a ? OWN_A : req_b ? OWN_B : IDLE;
                default: state_next = IDLE;
            endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end

`ifdef BLINK_EN
    logic [5:0] frame_cnt;
    logic [NUM_DIGITS-1:0] mask_snap;
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
            mask_snap <= '0;
        end else if (frame_boundary) begin
            frame_cnt <= frame_cnt + 6'd1;
            mask_snap <= state_next == IDLE ? '0 : blink_mask;
        end
    end
    assign dark = blank || state == IDLE || (frame_cnt[5] && mask_snap[slot]);
`else
    assign dark = blank || state == IDLE;
`endif

    // Digits and owner change together at the boundary so a frame never mixes sources.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold <= '0;
            snap <= '0;
            frame_start <= 1'b0;
            led_output <= '0;
            an <= ANODE_OFF;
        end else begin
            frame_start <= frame_boundary;
            an <= dark ? ANODE_OFF : ANODE_ON[slot];
            if (!blank) led_output <= snap[slot];
            if (frame_boundary) begin
                hold <= state_next != state ? 8'd1 : eligible ? hold : hold + 8'd1;
                snap <= state_next == OWN_A ? dig_a : state_next == OWN_B ? dig_b : '0;
            end
        end
    end
endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: randomized and directed checks against a frame-level reference model.
`timescale 1ns/1ps
module tb_seg_display_arbiter;
    localparam int P = 8, BL = 2, HF = 2, FRAME = 4 * P;
    logic clk = 0, reset = 1, req_a = 0, req_b = 0;
    logic [19:0] dig_a = 0, dig_b = 0;
`ifdef BLINK_EN
    logic [3:0] blink_mask = 0;
`endif
    logic gnt_a, gnt_b, frame_start;
    logic [4:0] led_output;
    logic [3:0] an;
    logic [11:0] obs_vec, exp_vec;
    int passed = 0, total = 0;
    int n, owner, owned, fc;
    int snap[4], msk[4];
    logic [4:0] m_led;
    logic [3:0] m_an;
    bit m_fs;

    seg_display_arbiter #(.PERIOD(P), .BLANK_CYC(BL), .HOLD_FRAMES(HF)) dut (
        .clk(clk), .reset(reset), .req_a(req_a), .dig_a(dig_a), .req_b(req_b), .dig_b(dig_b),
`ifdef BLINK_EN
        .blink_mask(blink_mask),
`endif
        .gnt_a(gnt_a), .gnt_b(gnt_b), .frame_start(frame_start), .led_output(led_output), .an(an));

    assign obs_vec = {gnt_a, gnt_b, frame_start, led_output, an};
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    // One clock of the reference: time is cycle count n since reset; ownership changes per frame.
    task automatic step();
        int t, s, nxt;
        @(posedge clk);
        if (reset) begin
            n = 0; owner = 0; owned = 0; fc = 0; m_led = 0; m_an = 4'hF; m_fs = 0;
            for (int d = 0; d < 4; d++) begin snap[d] = 0; msk[d] = 0; end
        end else begin
            t = n % P;
            s = (n / P) % 4;
            m_an = (t < BL || owner == 0) ? 4'hF : 4'(~(1 << s));
            if (fc >= 32 && msk[s] != 0) m_an = 4'hF;
            if (t >= BL) m_led = 5'(snap[s]);
            m_fs = (t == P - 1 && s == 3);
            if (m_fs) begin
                nxt = (owner != 0 && owned < HF) ? owner : req_a ? 1 : req_b ? 2 : 0;
                owned = (nxt != owner) ? 1 : (owned < HF ? owned + 1 : owned);
                owner = nxt;
                fc = (fc + 1) % 64;
                for (int d = 0; d < 4; d++) begin
                    snap[d] = owner == 1 ? int'(dig_a[5*d +: 5]) : owner == 2 ? int'(dig_b[5*d +: 5]) : 0;
`ifdef BLINK_EN
                    msk[d] = owner == 0 ? 0 : int'(blink_mask[d]);
`endif
                end
            end
            n++;
        end
        exp_vec = {owner == 1, owner == 2, m_fs, m_led, m_an};
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        step();
        total++; if (obs_vec !== 12'h00F) $display("FAIL reset_state: got %h want 00f", obs_vec); else passed++;
        total++; if (obs_vec !== exp_vec) $display("FAIL reset_model: got %h want %h", obs_vec, exp_vec); else passed++;
        reset = 0;
    endtask

    task automatic test_idle();
        int pulses = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step();
            pulses += int'(frame_start);
            total++; if (obs_vec !== exp_vec) $display("FAIL idle cyc %0d: got %h want %h", i, obs_vec, exp_vec); else passed++;
        end
        total++; if (pulses !== 3) $display("FAIL idle_frame_pulses: got %0d want 3", pulses); else passed++;
    endtask

    task automatic test_grant_a();
        bit saw3 = 0, saw1 = 0;
        test_reset();
        req_a = 1;
        dig_a = 20'h0C8A3;
        for (int i = 0; i < 4 * FRAME; i++) begin
            step();
            if (an == 4'b1110 && led_output == 5'd3) saw3 = 1;
            if (an == 4'b0111 && led_output == 5'd1) saw1 = 1;
            total++; if (obs_vec !== exp_vec) $display("FAIL grant_a cyc %0d: got %h want %h", i, obs_vec, exp_vec); else passed++;
        end
        total++; if ({saw3, saw1} !== 2'b11) $display("FAIL grant_a_digits: got %b want 11", {saw3, saw1}); else passed++;
        req_a = 0;
    endtask

    task automatic test_both();
        int k;
        test_reset();
        req_a = 1; req_b = 1;
        dig_a = 20'($urandom); dig_b = 20'($urandom);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            total++; if (obs_vec !== exp_vec) $display("FAIL both cyc %0d: got %h want %h", i, obs_vec, exp_vec); else passed++;
        end
        total++; if ({gnt_a, gnt_b} !== 2'b10) $display("FAIL both_a_wins: got %b want 10", {gnt_a, gnt_b}); else passed++;
        req_a = 0;
        for (k = 1; k <= 200; k++) begin
            step();
            total++; if (obs_vec !== exp_vec) $display("FAIL handoff cyc %0d: got %h want %h", k, obs_vec, exp_vec); else passed++;
            if (gnt_b) break;
        end
        total++; if (k !== 32) $display("FAIL handoff_latency: got %0d want 32", k); else passed++;
        req_b = 0;
    endtask

    task automatic test_preempt();
        int k;
        test_reset();
        req_b = 1;
        dig_b = 20'($urandom);
        for (int i = 0; i < 48; i++) begin
            step();
            total++; if (obs_vec !== exp_vec) $display("FAIL preempt_pre cyc %0d: got %h want %h", i, obs_vec, exp_vec); else passed++;
        end
        req_a = 1;
        dig_a = 20'($urandom);
        for (k = 1; k <= 200; k++) begin
            if (k == 20) dig_b = 20'($urandom);
            step();
            total++; if (obs_vec !== exp_vec) $display("FAIL preempt cyc %0d: got %h want %h", k, obs_vec, exp_vec); else passed++;
            if (gnt_a) break;
        end
        total++; if (k !== 48) $display("FAIL preempt_latency: got %0d want 48", k); else passed++;
        req_a = 0; req_b = 0;
    endtask

    task automatic test_reset_mid();
        int k;
        test_reset();
        req_a = 1;
        dig_a = 20'($urandom);
        for (int i = 0; i < 45; i++) step();
        total++; if (gnt_a !== 1'b1) $display("FAIL reset_mid_owned: got %b want 1", gnt_a); else passed++;
        reset = 1;
        step();
        total++; if ({gnt_a, an} !== 5'b01111) $display("FAIL reset_mid: got %b want 01111", {gnt_a, an}); else passed++;
        reset = 0;
        for (k = 1; k <= 100; k++) begin
            step();
            total++; if (obs_vec !== exp_vec) $display("FAIL reset_mid cyc %0d: got %h want %h", k, obs_vec, exp_vec); else passed++;
            if (frame_start) break;
        end
        total++; if (k !== 32) $display("FAIL reset_mid_restart: got %0d want 32", k); else passed++;
        req_a = 0;
    endtask

    task automatic test_random();
        test_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(39) == 0) req_a = ~req_a;
            if ($urandom_range(29) == 0) req_b = ~req_b;
            if ($urandom_range(9) == 0) dig_a = 20'($urandom);
            if ($urandom_range(9) == 0) dig_b = 20'($urandom);
            step();
            total++; if (obs_vec !== exp_vec) $display("FAIL random cyc %0d: got %h want %h", i, obs_vec, exp_vec); else passed++;
        end
        req_a = 0; req_b = 0;
    endtask

`ifdef BLINK_EN
    task automatic test_blink();
        test_reset();
        req_a = 1;
        blink_mask = 4'b0001;
        dig_a = 20'($urandom);
        for (int i = 0; i < 66 * FRAME; i++) begin
            step();
            total++; if (obs_vec !== exp_vec) $display("FAIL blink cyc %0d: got %h want %h", i, obs_vec, exp_vec); else passed++;
        end
        req_a = 0;
        blink_mask = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_idle();
        test_grant_a();
        test_both();
        test_preempt();
        test_reset_mid();
        test_random();
`ifdef BLINK_EN
        test_blink();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
